// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit and MEM/WB pipeline register.
//
// Takes one instruction from EX/MEM per cycle. Loads and stores go out over a
// req/gnt/rvalid data bus. Load data is formatted by size and sign before it
// is captured into MEM/WB. While an access is outstanding, mem_stall holds
// the upstream stages.
//
// Parameters:
//   BUS_TIMEOUT  cycles spent in WAIT without rvalid before a load is aborted
//                (0 disables the timeout)
//
// Optional feature (compile-time macro LSU_MISALIGN_EXC_EN):
//   When defined, a misaligned half/word access issues no bus request. It is
//   written into MEM/WB with RegWrite cleared, and mem_misalign pulses.
//   When undefined, misaligned addresses are aligned down silently.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   ex_*                    EX/MEM slot: valid, ALU result/address, store data,
//                           MemRead, MemWrite, MemtoReg, RegWrite, rd, funct3
//   dmem_req/we/addr/wdata/be  bus request (held stable until dmem_gnt)
//   dmem_gnt/rvalid/rdata   bus response
//   mem_stall               hold EX/MEM and earlier stages
//   mem_bus_err             one-cycle pulse on load timeout (aligned with wb_valid)
//   mem_misalign            one-cycle pulse on misaligned op (macro only)
//   wb_*                    registered MEM/WB payload
module mem_stage_lsu #(
    parameter int unsigned BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic        ex_MemtoReg,
    input  logic        ex_RegWrite,
    input  logic [4:0]  ex_rd,
    input  logic [2:0]  ex_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_bus_err,
`ifdef LSU_MISALIGN_EXC_EN
    output logic        mem_misalign,
`endif
    output logic        wb_valid,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_mem_read_data,
    output logic        wb_MemtoReg,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_rd
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state, state_nx;
    logic [31:0] cnt;

    // Copy of the op taken when it leaves IDLE, so the bus request and the
    // MEM/WB payload do not depend on the stalled EX/MEM inputs.
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_we, r_memtoreg, r_regwrite;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;

    logic        in_idle, is_mem, misalign, mis_now, start;
    logic        req, done, tmo, expire, fire;
    logic [31:0] st_wdata, ld_fmt, ld_data;
    logic [3:0]  st_be;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_we, cur_memtoreg, cur_regwrite;
    logic [4:0]  cur_rd;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign in_idle = (state == IDLE);
    assign is_mem  = ex_valid & (ex_MemRead | ex_MemWrite);

`ifdef LSU_MISALIGN_EXC_EN
    assign misalign = is_mem &
                      (((ex_funct3[1:0] == 2'b01) & ex_alu_result[0]) |
                       (ex_funct3[1] & (ex_alu_result[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign mis_now = in_idle & misalign;
    assign start   = in_idle & is_mem & ~misalign;

    // Store lane alignment from the EX/MEM inputs
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ex_alu_result[1:0];
                st_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                st_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // In IDLE the request is driven straight from EX/MEM; afterwards from the copy
    assign cur_addr     = in_idle ? ex_alu_result : r_addr;
    assign cur_wdata    = in_idle ? st_wdata      : r_wdata;
    assign cur_be       = in_idle ? st_be         : r_be;
    assign cur_we       = in_idle ? ex_MemWrite   : r_we;
    assign cur_memtoreg = in_idle ? ex_MemtoReg   : r_memtoreg;
    assign cur_regwrite = in_idle ? ex_RegWrite   : r_regwrite;
    assign cur_rd       = in_idle ? ex_rd         : r_rd;

    assign expire = (BUS_TIMEOUT != 0) && (cnt == BUS_TIMEOUT - 1);

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        done     = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    req = 1'b1;
                    if (!dmem_gnt)        state_nx = REQ;
                    else if (ex_MemWrite) done = 1'b1;
                    else                  state_nx = WAIT;
                end
            end
            REQ: begin
                req = 1'b1;
                if (dmem_gnt) begin
                    if (r_we) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                // rvalid takes priority over a timeout expiring in the same cycle
                if (dmem_rvalid) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (expire) begin
                    done     = 1'b1;
                    tmo      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Load formatting; half lanes ignore addr[0] (aligned down)
    assign bsel = dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign hsel = dmem_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (r_funct3)
            3'b000:  ld_fmt = {{24{bsel[7]}}, bsel};
            3'b100:  ld_fmt = {24'b0, bsel};
            3'b001:  ld_fmt = {{16{hsel[15]}}, hsel};
            3'b101:  ld_fmt = {16'b0, hsel};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    assign ld_data = ((state == WAIT) && dmem_rvalid) ? ld_fmt : '0;

    // Bus outputs and stall are forced low while reset is asserted
    assign dmem_req   = req & rst_n;
    assign dmem_we    = dmem_req & cur_we;
    assign dmem_addr  = dmem_req ? {cur_addr[31:2], 2'b00} : '0;
    assign dmem_wdata = dmem_req ? cur_wdata : '0;
    assign dmem_be    = dmem_req ? cur_be : '0;
    assign mem_stall  = rst_n & (in_idle ? (start & ~done) : ~done);

    // MEM/WB capture: non-memory and misaligned ops in IDLE, or any completion
    assign fire = in_idle ? (ex_valid & (~is_mem | misalign | done)) : done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_be             <= '0;
            r_we             <= 1'b0;
            r_memtoreg       <= 1'b0;
            r_regwrite       <= 1'b0;
            r_funct3         <= '0;
            r_rd             <= '0;
            mem_bus_err      <= 1'b0;
            wb_valid         <= 1'b0;
            wb_alu_result    <= '0;
            wb_mem_read_data <= '0;
            wb_MemtoReg      <= 1'b0;
            wb_RegWrite      <= 1'b0;
            wb_rd            <= '0;
`ifdef LSU_MISALIGN_EXC_EN
            mem_misalign     <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if ((state == WAIT) && (state_nx == WAIT)) cnt <= cnt + 32'd1;
            else                                       cnt <= '0;
            if (start) begin
                r_addr     <= ex_alu_result;
                r_wdata    <= st_wdata;
                r_be       <= st_be;
                r_we       <= ex_MemWrite;
                r_memtoreg <= ex_MemtoReg;
                r_regwrite <= ex_RegWrite;
                r_funct3   <= ex_funct3;
                r_rd       <= ex_rd;
            end
            mem_bus_err <= tmo;
`ifdef LSU_MISALIGN_EXC_EN
            mem_misalign <= mis_now;
`endif
            wb_valid <= fire;
            if (fire) begin
                wb_alu_result    <= cur_addr;
                wb_mem_read_data <= ld_data;
                wb_MemtoReg      <= cur_memtoreg;
                wb_RegWrite      <= cur_regwrite & ~tmo & ~mis_now;
                wb_rd            <= cur_rd;
            end else begin
                wb_RegWrite      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    localparam int T = 16;
    localparam int K_BUB = 0;
    localparam int K_ALU = 1;
    localparam int K_LD  = 2;
    localparam int K_ST  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, mem_bus_err;
    logic        wb_valid, wb_MemtoReg, wb_RegWrite;
    logic [31:0] wb_alu_result, wb_mem_read_data;
    logic [4:0]  wb_rd;

    always #5 clk = ~clk;

    mem_stage_lsu #(.BUS_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg),
        .ex_RegWrite(ex_RegWrite), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .mem_bus_err(mem_bus_err),
        .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
        .wb_mem_read_data(wb_mem_read_data), .wb_MemtoReg(wb_MemtoReg),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd)
    );

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        m2r;
        logic        rw;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference load formatting: pick the lane arithmetically, then extend
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                                input logic [2:0] f3);
        longint v;
        int off;
        off = int'(a % 4);
        case (f3)
            3'd0, 3'd4: begin
                v = longint'((w >> (8 * off)) & 32'hFF);
                if (f3 == 3'd0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd5: begin
                v = longint'((w >> (16 * (off / 2))) & 32'hFFFF);
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    // Monitor: pops one expectation per MEM/WB valid cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (wb_valid) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wb_unexpected: wb_valid=1 with no expected op (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("wb_alu_result", wb_alu_result, e.alu);
                    check("wb_mem_read_data", wb_mem_read_data, e.rdata);
                    check1("wb_MemtoReg", wb_MemtoReg, e.m2r);
                    check1("wb_RegWrite", wb_RegWrite, e.rw);
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                    check1("mem_bus_err", mem_bus_err, e.err);
                end
            end else begin
                check1("wb_RegWrite_novalid", wb_RegWrite, 1'b0);
                check1("mem_bus_err_novalid", mem_bus_err, 1'b0);
            end
        end
    end

    // g: cycle (from issue) on which gnt is given; r: cycles after gnt until
    // rvalid (r > T means the load times out and rvalid arrives late)
    task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [2:0] f3, input int g, input int r,
                         input logic [31:0] rdata);
        int done_c;
        int off;
        bit tmo;
        bit is_mem;
        bit exp_req;
        exp_t e;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        is_mem        = (kind == K_LD) || (kind == K_ST);
        ex_valid      = (kind != K_BUB);
        ex_MemRead    = (kind == K_LD);
        ex_MemWrite   = (kind == K_ST);
        ex_alu_result = addr;
        ex_store_data = sdata;
        ex_funct3     = f3;
        ex_rd         = 5'($urandom);
        ex_MemtoReg   = 1'($urandom);
        ex_RegWrite   = 1'($urandom);
        tmo    = 1'b0;
        done_c = 0;
        if (kind == K_ST) done_c = g;
        else if (kind == K_LD) begin
            if (r <= T) done_c = g + r;
            else begin
                done_c = g + T;
                tmo    = 1'b1;
            end
        end
        off = int'(addr % 4);
        case (f3 % 4)
            3'd0: begin
                ebe = 4'(1 << off);
                ewd = (sdata % 256) * 32'h01010101;
            end
            3'd1: begin
                ebe = (off >= 2) ? 4'hC : 4'h3;
                ewd = (sdata % 65536) * 32'h00010001;
            end
            default: begin
                ebe = 4'hF;
                ewd = sdata;
            end
        endcase
        if (kind != K_BUB) begin
            e.alu   = addr;
            e.rdata = (kind == K_LD && !tmo) ? model_load(rdata, addr, f3) : 32'h0;
            e.m2r   = ex_MemtoReg;
            e.rw    = ex_RegWrite & ~tmo;
            e.rd    = ex_rd;
            e.err   = tmo;
            q.push_back(e);
        end
        for (int c = 0; c <= done_c; c++) begin
            dmem_gnt    = is_mem && (c == g);
            dmem_rvalid = (kind == K_LD) && (c == g + r);
            dmem_rdata  = dmem_rvalid ? rdata : $urandom;
            @(negedge clk);
            exp_req = is_mem && (c <= g);
            check1("dmem_req", dmem_req, exp_req);
            check1("mem_stall", mem_stall, is_mem && (c < done_c));
            if (exp_req) begin
                check("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
                check1("dmem_we", dmem_we, kind == K_ST);
                if (kind == K_ST) begin
                    check("dmem_be", 32'(dmem_be), 32'(ebe));
                    check("dmem_wdata", dmem_wdata, ewd);
                end
            end
            @(posedge clk);
            #1;
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (tmo) begin
            // Idle cycles that deliver the late rvalid, which must be ignored
            for (int c = done_c + 1; c <= g + r; c++) begin
                ex_valid    = 1'b0;
                ex_MemRead  = 1'b0;
                ex_MemWrite = 1'b0;
                dmem_rvalid = (c == g + r);
                dmem_rdata  = rdata;
                @(negedge clk);
                check1("dmem_req_late", dmem_req, 1'b0);
                @(posedge clk);
                #1;
            end
            dmem_rvalid = 1'b0;
        end
    endtask

    initial begin
        int k, kind, g, r, p;
        logic [2:0] f3;
        rst_n = 1'b0;
        ex_valid = 1'b1; ex_MemRead = 1'b1; ex_MemWrite = 1'b0;
        ex_MemtoReg = 1'b1; ex_RegWrite = 1'b1; ex_rd = 5'd3; ex_funct3 = 3'd2;
        ex_alu_result = 32'h100; ex_store_data = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #2;
        check1("rst_dmem_req", dmem_req, 1'b0);
        check1("rst_mem_stall", mem_stall, 1'b0);
        check1("rst_wb_valid", wb_valid, 1'b0);
        check1("rst_wb_RegWrite", wb_RegWrite, 1'b0);
        check("rst_wb_alu_result", wb_alu_result, 32'h0);
        check("rst_wb_mem_read_data", wb_mem_read_data, 32'h0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        check1("rst_mem_bus_err", mem_bus_err, 1'b0);
        ex_valid = 1'b0; ex_MemRead = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases
        do_op(K_LD, 32'h100, 32'h0, 3'b010, 0, 2, 32'hDEADBEEF);
        do_op(K_LD, 32'h103, 32'h0, 3'b000, 0, 1, 32'h80FFFF7F);
        do_op(K_LD, 32'h103, 32'h0, 3'b100, 1, 1, 32'h80FFFF7F);
        do_op(K_LD, 32'h102, 32'h0, 3'b001, 0, 3, 32'h80FFFF7F);
        do_op(K_LD, 32'h102, 32'h0, 3'b101, 0, 1, 32'h80FFFF7F);
        do_op(K_ST, 32'h201, 32'h000000AB, 3'b000, 3, 0, 32'h0);
        do_op(K_ST, 32'h202, 32'h1234ABCD, 3'b001, 0, 0, 32'h0);
        do_op(K_ST, 32'h204, 32'h1234ABCD, 3'b010, 0, 0, 32'h0);
        do_op(K_ST, 32'h207, 32'h55AA55AA, 3'b010, 0, 0, 32'h0);
        do_op(K_LD, 32'h300, 32'h0, 3'b010, 0, T + 2, 32'hCAFEF00D);
        do_op(K_LD, 32'h304, 32'h0, 3'b010, 1, T, 32'h0BADF00D);
        do_op(K_LD, 32'h308, 32'h0, 3'b110, 0, 1, 32'h76543210);
        do_op(K_ALU, 32'h00001234, 32'h0, 3'b000, 0, 0, 32'h0);
        do_op(K_BUB, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
        do_op(K_LD, 32'h400, 32'h0, 3'b010, 0, 1, 32'h11223344);
        do_op(K_BUB, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);

        // Reset while a load sits in WAIT
        ex_valid = 1'b1; ex_MemRead = 1'b1; ex_MemWrite = 1'b0;
        ex_alu_result = 32'h500; ex_funct3 = 3'b010; ex_RegWrite = 1'b1; ex_rd = 5'd9;
        dmem_gnt = 1'b1;
        @(negedge clk);
        check1("rstw_req_issue", dmem_req, 1'b1);
        check("rstw_queue_empty", 32'(q.size()), 32'h0);
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check1("rstw_dmem_req", dmem_req, 1'b0);
        check1("rstw_mem_stall", mem_stall, 1'b0);
        check1("rstw_wb_valid", wb_valid, 1'b0);
        check1("rstw_wb_RegWrite", wb_RegWrite, 1'b0);
        check("rstw_wb_alu_result", wb_alu_result, 32'h0);
        check("rstw_wb_mem_read_data", wb_mem_read_data, 32'h0);
        check("rstw_wb_rd", 32'(wb_rd), 32'h0);
        ex_valid = 1'b0; ex_MemRead = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check1("rstw_late_rvalid_ignored", wb_valid, 1'b0);
        @(posedge clk); #1;
        do_op(K_LD, 32'h504, 32'h0, 3'b010, 0, 1, 32'hA5A5A5A5);

        // Random traffic
        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 9);
            kind = (k == 0) ? K_BUB : (k <= 2) ? K_ALU : (k <= 6) ? K_LD : K_ST;
            g = $urandom_range(0, 3);
            p = $urandom_range(0, 24);
            if (p == 0)      r = T + 1 + $urandom_range(0, 2);
            else if (p == 1) r = T;
            else             r = $urandom_range(1, 4);
            f3 = (kind == K_ST) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            do_op(kind, $urandom, $urandom, f3, g, r, $urandom);
        end

        do_op(K_BUB, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
        do_op(K_BUB, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
        check("final_queue_empty", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
